// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default bit timing and the
// transmit-drain state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int STOP_BITS            = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 868;  // 100 MHz / 115200

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_t;

endpackage

// File: rtl/uart_tx_drain_if.sv
// Command, buffer read port and serial/status signals of the UART drain.
interface uart_tx_drain_if #(
  parameter int ADDR_W = 10
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (
    output start, base_addr, len, mem_rd,
    input  mem_addr, tx, busy, done
  );

  modport slave (
    input  start, base_addr, len, mem_rd,
    output mem_addr, tx, busy, done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: load restarts the period, en advances it, and bit_tick
// marks the last cycle of each CLKS_PER_BIT-long bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic bit_tick
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = en && !load && (count == LAST);

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// Reads a run of words from the UART buffer and shifts their low bytes out
// on tx as 8N1 frames, one start/len command at a time.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 10
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_drain_if.slave bus
);

  if (STOP_BITS != 1 || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_param_check
    $error("uart_tx_drain: unsupported STOP_BITS or CLKS_PER_BIT");
  end

  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W + 1)'(1);

  state_t            state, next_state;
  logic [7:0]        shift_q;
  logic [2:0]        bit_idx;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] addr_q;
  logic              tx_q, busy_q, done_q;
  logic              tx_next;
  logic              baud_load, baud_en, bit_tick;

  // Only the character byte matters; the upper word bits are don't-care.
  logic unused_rd_hi;
  assign unused_rd_hi = ^bus.mem_rd[31:8];

  assign bus.mem_addr = addr_q;
  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (CLK),
    .rst     (RST),
    .load    (baud_load),
    .en      (baud_en),
    .bit_tick(bit_tick)
  );

  // tx_next is the line level for the coming cycle, so the registered tx
  // changes on the same edge as the state and never lags into STOP/FETCH.
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    next_state = state;
    tx_next    = 1'b1;
    baud_load  = 1'b0;
    baud_en    = 1'b0;
    case (state)
      S_IDLE:  if (bus.start) next_state = (bus.len == '0) ? S_FIN : S_FETCH;
      S_FETCH: next_state = S_WAIT;
      S_WAIT: begin
        next_state = S_START;
        baud_load  = 1'b1;
        tx_next    = 1'b0;
      end
      S_START: begin
        baud_en = 1'b1;
        tx_next = 1'b0;
        if (bit_tick) begin
          next_state = S_DATA;
          tx_next    = shift_q[0];
        end
      end
      S_DATA: begin
        baud_en = 1'b1;
        tx_next = shift_q[0];
        if (bit_tick) begin
          if (bit_idx == LAST_BIT) begin
            next_state = S_STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = shift_q[1];
          end
        end
      end
      S_STOP: begin
        baud_en = 1'b1;
        if (bit_tick) next_state = (remaining == ONE) ? S_FIN : S_FETCH;
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Reset aborts any frame in flight; the line goes idle-high at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      remaining <= '0;
      shift_q   <= '0;
      bit_idx   <= '0;
    end else begin
      state  <= next_state;
      tx_q   <= tx_next;
      busy_q <= (next_state != S_IDLE);
      done_q <= (next_state == S_FIN);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            addr_q    <= bus.base_addr;
            remaining <= bus.len;
          end
        end
        S_WAIT: begin
          shift_q <= bus.mem_rd[7:0];
          bit_idx <= '0;
        end
        S_DATA: begin
          if (bit_tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            remaining <= remaining - 1'b1;
            addr_q    <= addr_q + 1'b1;  // wraps at the top of the buffer
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Self-checking bench for uart_tx_drain: directed table, reset abort and
// randomized commands against a cycle-level model of the serial waveform.
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int C  = 4;
  localparam int AW = 10;
  localparam int P  = 2 + (1 + UART_DATA_BITS + STOP_BITS) * C;  // cycles per character

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_drain_if #(.ADDR_W(AW)) bus ();

  uart_tx_drain #(
    .CLKS_PER_BIT(C),
    .ADDR_W      (AW)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  // Buffer model: registered read, data valid one cycle after the address.
  logic [31:0] mem [0:1023];
  always @(posedge clk) bus.mem_rd <= mem[bus.mem_addr];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic txs [0:511];

  typedef struct packed {
    logic [9:0]       base;
    logic [10:0]      len;
    logic [2:0][31:0] w;
    logic [2:0][7:0]  ch;
    logic             noise;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected tx level k cycles after the accepting edge of a command.
  function automatic logic exp_tx(input int k, input int n, input logic [2:0][7:0] chars);
    int i, o, b;
    if (k < 1 || k > n * P) return 1'b1;
    i = (k - 1) / P;
    o = (k - 1) % P;
    if (o < 2) return 1'b1;
    b = (o - 2) / C;
    if (b == 0) return 1'b0;
    if (b <= UART_DATA_BITS) return chars[i][b-1];
    return 1'b1;
  endfunction

  function automatic vec_t mk(input int base, input int len, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2,
                              input logic [7:0] c0, input logic [7:0] c1,
                              input logic [7:0] c2, input logic noise);
    vec_t v;
    v.base  = 10'(base);
    v.len   = 11'(len);
    v.w     = {w2, w1, w0};
    v.ch    = {c2, c1, c0};
    v.noise = noise;
    return v;
  endfunction

  // Issues one command in the current cycle and checks every cycle through
  // the cycle after done; optional spurious starts mid-frame and on done.
  task automatic run_cmd(input logic [9:0] base, input int n, input logic noise,
                         output logic [2:0][7:0] dec);
    logic [2:0][7:0] chars;
    logic [2:0]      exp3;
    int              total, o;
    chars = '0;
    dec   = '0;
    for (int i = 0; i < n; i++) chars[i] = mem[(int'(base) + i) % 1024][7:0];
    total = n * P + 1;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.len       = 11'(n);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      txs[k] = bus.tx;
      exp3 = {exp_tx(k, n, chars), 1'(k <= total), 1'(k == total)};
      check($sformatf("b%0d n%0d cyc%0d tx/busy/done", base, n, k),
            {29'd0, bus.tx, bus.busy, bus.done}, {29'd0, exp3});
      o = (k - 1) % P;
      if (k <= n * P && o < 2)
        check($sformatf("b%0d n%0d cyc%0d mem_addr", base, n, k),
              {22'd0, bus.mem_addr}, (int'(base) + (k - 1) / P) % 1024);
      if (k == total)
        check($sformatf("b%0d n%0d final mem_addr", base, n),
              {22'd0, bus.mem_addr}, (int'(base) + n) % 1024);
      if (noise && (k == 5 || k == total)) begin
        bus.start     = 1'b1;
        bus.base_addr = base + 10'd7;
        bus.len       = 11'(n + 1);
      end
    end
    bus.start = 1'b0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        dec[i][b] = txs[i * P + 3 + (b + 1) * C + C / 2];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t            vecs [5];
    logic [2:0][7:0] dec;
    logic [9:0]      rbase;
    int              rn;
    logic            rnoise;

    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.len       = '0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset tx",       {31'd0, bus.tx},   32'd1);
    check("reset busy",     {31'd0, bus.busy}, 32'd0);
    check("reset done",     {31'd0, bus.done}, 32'd0);
    check("reset mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    vecs[0] = mk(5,    1, 32'h0000_0055, 32'h0,  32'h0,  8'h55, 8'h00, 8'h00, 1'b0);
    vecs[1] = mk(0,    3, 32'hFFFF_FF41, 32'h42, 32'h43, 8'h41, 8'h42, 8'h43, 1'b0);
    vecs[2] = mk(1023, 2, 32'h0000_0031, 32'h32, 32'h0,  8'h31, 8'h32, 8'h00, 1'b0);
    vecs[3] = mk(200,  0, 32'h0,         32'h0,  32'h0,  8'h00, 8'h00, 8'h00, 1'b0);
    vecs[4] = mk(10,   2, 32'hABCD_005A, 32'hA5, 32'h0,  8'h5A, 8'hA5, 8'h00, 1'b1);

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < int'(vecs[v].len); i++)
        mem[(int'(vecs[v].base) + i) % 1024] = vecs[v].w[i];
      run_cmd(vecs[v].base, int'(vecs[v].len), vecs[v].noise, dec);
      for (int i = 0; i < int'(vecs[v].len); i++)
        check($sformatf("vec%0d char%0d", v, i), {24'd0, dec[i]}, {24'd0, vecs[v].ch[i]});
    end

    // Reset in the middle of DATA bit 3 of 0x55 (a zero bit).
    mem[5] = 32'h0000_0055;
    bus.start     = 1'b1;
    bus.base_addr = 10'd5;
    bus.len       = 11'd1;
    for (int k = 1; k <= 3 + 4 * C + 1; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("pre-reset tx bit3", {31'd0, bus.tx}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("async reset tx",   {31'd0, bus.tx},   32'd1);
    check("async reset busy", {31'd0, bus.busy}, 32'd0);
    check("async reset done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(10'd5, 1, 1'b0, dec);
    check("post-reset char", {24'd0, dec[0]}, 32'h55);

    for (int t = 0; t < 8; t++) begin
      rbase  = 10'($urandom_range(0, 1023));
      rn     = $urandom_range(0, 3);
      rnoise = 1'($urandom_range(0, 1));
      for (int i = 0; i < rn; i++) mem[(int'(rbase) + i) % 1024] = $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_cmd(rbase, rn, rnoise, dec);
      for (int i = 0; i < rn; i++)
        check($sformatf("rand%0d char%0d", t, i), {24'd0, dec[i]},
              {24'd0, mem[(int'(rbase) + i) % 1024][7:0]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
